// File: rtl/fifo_drain.sv
// fifo_drain: pops a requested burst of words from a show-ahead FIFO onto a valid/ready stream.
// Define FIFO_DRAIN_CNT_EN to add rd_count, a 16-bit wrapping count of FIFO pops.
module fifo_drain #(
  parameter int DW = 32,
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] fifo_data,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic          start,
  input  logic [LW-1:0] burst_len,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]   rd_count
`endif
);

  localparam int MAX_BURST = 32;

  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

  state_t        state_q;
  logic [LW-1:0] remaining_q;
  logic [DW-1:0] m_data_q;
  logic          m_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          len_ok;

  assign len_ok = (burst_len != '0) && (32'(burst_len) <= 32'(MAX_BURST));

  // A pop is allowed whenever the output slot is empty or being drained this cycle.
  assign fifo_rd_en = (state_q == ACTIVE) && (remaining_q != '0) && !fifo_empty &&
                      (!m_valid_q || m_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (fifo_rd_en) begin
        m_data_q  <= fifo_data;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start && len_ok) begin
            remaining_q <= burst_len;
            state_q     <= ACTIVE;
            busy_q      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (fifo_rd_en) begin
            remaining_q <= remaining_q - LW'(1);
          end else if ((remaining_q == '0) && (!m_valid_q || m_ready)) begin
            // Last word has left (or is leaving) the output register.
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] rd_count_q;
  logic [15:0] rd_count_d;

  assign rd_count_d = fifo_rd_en ? rd_count_q + 16'd1 : rd_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed bench for fifo_drain with a small show-ahead FIFO model and stream monitor.
// Define FIFO_DRAIN_CNT_EN to also exercise the rd_count wrap.
module tb_fifo_drain;
  localparam int DW = 32;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          done;
`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0]   rd_count;
`endif

  fifo_drain #(.DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .start      (start),
    .burst_len  (burst_len),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Show-ahead FIFO model: head word visible while non-empty, popped on edges with fifo_rd_en.
  logic [DW-1:0] fmem [0:63];
  logic [6:0]    wr_ptr = '0;
  logic [6:0]    rd_ptr = '0;
  logic          flush = 1'b0;
  int            pop_cnt = 0;
  int            uf_cnt = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = fmem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo_empty) uf_cnt <= uf_cnt + 1;
      else            rd_ptr <= rd_ptr + 7'd1;
    end
  end

  // Stream monitor, sampled mid-cycle while inputs are stable.
  logic [DW-1:0] acc_q[$];
  int            acc_cyc[$];
  int            mon_cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always begin
    @(negedge clk);
    #3;
    mon_cyc++;
    if (prev_stall && rst_n) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
    end
    if (rst_n && m_valid && m_ready) begin
      acc_q.push_back(m_data);
      acc_cyc.push_back(mon_cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = mon_cyc;
    end
    prev_stall = rst_n && m_valid && !m_ready;
    prev_data  = m_data;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d);
    fmem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 7'd1;
  endtask

  task automatic pulse_start(input logic [LW-1:0] len);
    start     = 1'b1;
    burst_len = len;
    step(1);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin
      step(1);
      k++;
    end
    check({tag, "_idle"}, busy, 0);
    step(2);
  endtask

  task automatic expect_words(input string tag, input int base, input logic [31:0] first, input int n);
    check({tag, "_nwords"}, acc_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < acc_q.size()) check({tag, "_word"}, acc_q[base + i], first + i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base, p0, d0;

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_rden", fifo_rd_en, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Basic 4-word burst at full rate
    base = acc_q.size(); p0 = pop_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    pulse_start(6'd4);
    check("t1_busy", busy, 1);
    check("t1_rden", fifo_rd_en, 1);
    check("t1_valid0", m_valid, 0);
    wait_idle("t1", 40);
    expect_words("t1", base, 32'hA0, 4);
    check("t1_pops", pop_cnt - p0, 4);
    check("t1_done", done_cnt - d0, 1);
    if (acc_cyc.size() >= base + 4) begin
      check("t1_b2b", acc_cyc[base + 3] - acc_cyc[base], 3);
      check("t1_done_lat", done_cyc - acc_cyc[base + 3], 1);
    end

    // Downstream stall for two cycles after the first word
    base = acc_q.size(); p0 = pop_cnt; d0 = done_cnt;
    for (int i = 0; i < 3; i++) push(32'hB0 + i);
    pulse_start(6'd3);
    step(1);
    m_ready = 1'b0;
    #1;
    check("t2_stall_rden", fifo_rd_en, 0);
    check("t2_stall_valid", m_valid, 1);
    check("t2_stall_data", m_data, 32'hB0);
    step(1);
    check("t2_stall_pops", pop_cnt - p0, 1);
    check("t2_stall_data2", m_data, 32'hB0);
    step(1);
    m_ready = 1'b1;
    wait_idle("t2", 40);
    expect_words("t2", base, 32'hB0, 3);
    check("t2_pops", pop_cnt - p0, 3);
    check("t2_done", done_cnt - d0, 1);

    // FIFO runs dry mid-burst, refilled later
    base = acc_q.size(); p0 = pop_cnt; d0 = done_cnt;
    push(32'hC0); push(32'hC1);
    pulse_start(6'd5);
    step(2);
    check("t3_dry_rden", fifo_rd_en, 0);
    check("t3_dry_busy", busy, 1);
    check("t3_dry_pops", pop_cnt - p0, 2);
    step(1);
    for (int i = 2; i < 5; i++) push(32'hC0 + i);
    #1;
    check("t3_resume_rden", fifo_rd_en, 1);
    wait_idle("t3", 40);
    expect_words("t3", base, 32'hC0, 5);
    check("t3_pops", pop_cnt - p0, 5);
    check("t3_done", done_cnt - d0, 1);
    if (acc_cyc.size() >= base + 5) check("t3_done_lat", done_cyc - acc_cyc[base + 4], 1);

    // Illegal lengths and start while busy / in FINISH are ignored
    p0 = pop_cnt; d0 = done_cnt;
    pulse_start(6'd0);
    step(3);
    check("t4_len0_busy", busy, 0);
    pulse_start(6'd33);
    step(3);
    check("t4_len33_busy", busy, 0);
    check("t4_bad_pops", pop_cnt - p0, 0);
    base = acc_q.size();
    for (int i = 0; i < 4; i++) push(32'hD0 + i);
    pulse_start(6'd2);
    check("t4_busy", busy, 1);
    pulse_start(6'd5);
    wait_idle("t4", 40);
    expect_words("t4", base, 32'hD0, 2);
    check("t4_pops", pop_cnt - p0, 2);
    check("t4_done", done_cnt - d0, 1);
    base = acc_q.size(); p0 = pop_cnt;
    pulse_start(6'd2);
    step(3);
    check("t4_finish_done", done, 1);
    pulse_start(6'd3);
    check("t4_finish_ign", busy, 0);
    step(3);
    check("t4_finish_idle", busy, 0);
    expect_words("t4b", base, 32'hD2, 2);
    check("t4b_pops", pop_cnt - p0, 2);

    // Reset mid-burst after two of eight words
    base = acc_q.size(); p0 = pop_cnt; d0 = done_cnt;
    for (int i = 0; i < 8; i++) push(32'hE0 + i);
    pulse_start(6'd8);
    step(3);
    check("t5_pre_words", acc_q.size() - base, 2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_data", m_data, 0);
    check("t5_rst_rden", fifo_rd_en, 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("t5_post_busy", busy, 0);
    check("t5_pops", pop_cnt - p0, 3);
    check("t5_no_done", done_cnt - d0, 0);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("t5_flushed", fifo_empty, 1);
    base = acc_q.size(); d0 = done_cnt;
    push(32'hF0); push(32'hF1);
    pulse_start(6'd2);
    wait_idle("t5b", 40);
    expect_words("t5b", base, 32'hF0, 2);
    check("t5b_done", done_cnt - d0, 1);

    // Maximum burst length
    base = acc_q.size(); p0 = pop_cnt; d0 = done_cnt;
    for (int i = 0; i < 32; i++) push(32'h100 + i);
    pulse_start(6'd32);
    wait_idle("t6", 80);
    expect_words("t6", base, 32'h100, 32);
    check("t6_pops", pop_cnt - p0, 32);
    check("t6_done", done_cnt - d0, 1);
    if (acc_cyc.size() >= base + 32) check("t6_b2b", acc_cyc[base + 31] - acc_cyc[base], 31);

`ifdef FIFO_DRAIN_CNT_EN
    // rd_count wraps after 65536 pops
    rst_n = 1'b0;
    #1;
    check("t7_rst_cnt", rd_count, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    p0 = pop_cnt;
    for (int b = 0; b < 2048; b++) begin
      for (int i = 0; i < 32; i++) push(32'h2000 + i);
      pulse_start(6'd32);
      step(34);
      if (b == 0) check("t7_cnt32", rd_count, 32);
    end
    wait_idle("t7", 80);
    check("t7_pops", pop_cnt - p0, 65536);
    check("t7_wrap", rd_count, 0);
`endif

    check("no_underflow", uf_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
